alu_issue_stage: RTL and testbench

- Pipeline stage directly upstream of the ALU.
- Accepts decoded operands plus ALUOp/funct from the decode stage through a valid/ready handshake.
- Translates ALUOp/funct into the ALU's 4-bit control code.
- Holds operations in a 2-entry skid buffer so the ALU side can stall without a combinational ready path back to decode.

---
 rtl/alu_issue_stage_pkg.sv | 51 +++++
 rtl/alu_issue_stage_if.sv | 54 +++++
 rtl/alu_issue_stage_ctrl_dec.sv | 41 ++++
 rtl/alu_issue_stage.sv | 158 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types for the ALU issue stage and the ALU control
//            decoder: ALU control codes, ALUOp encodings, R-type funct
//            values and the buffered issue-entry record.
// Macros   : ALU_ISSUE_FORWARD_EN adds rs1/rs2 tags to issue_entry_t.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operand and register-tag widths carried by an issue entry.
    localparam int ISSUE_DATA_W = 32;
    localparam int ISSUE_REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_BAD = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        logic [ISSUE_DATA_W-1:0] src1;
        logic [ISSUE_DATA_W-1:0] src2;
        alu_ctrl_e               ctrl;
        logic [ISSUE_REG_AW-1:0] rd;
        logic                    illegal;
`ifdef ALU_ISSUE_FORWARD_EN
        logic [ISSUE_REG_AW-1:0] rs1;
        logic [ISSUE_REG_AW-1:0] rs2;
`endif
    } issue_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage_if
// Purpose  : Decode-side and ALU-side handshake/data bundle of the issue
//            stage. slave = the issue stage, master = its environment.
// Ports    : in_*  decode -> stage (valid/ready, operands, ALUOp/funct, rd)
//            out_* stage -> ALU (valid/ready, operands, ctrl, rd, illegal)
// Macros   : ALU_ISSUE_FORWARD_EN adds in_rs1_i/in_rs2_i source tags.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if #(
    parameter int DATA_W = alu_pkg::ISSUE_DATA_W,
    parameter int REG_AW = alu_pkg::ISSUE_REG_AW
) ();
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_src1_i;
    logic [DATA_W-1:0] in_src2_i;
    logic [1:0]        in_aluop_i;
    logic [5:0]        in_funct_i;
    logic [REG_AW-1:0] in_rd_i;
`ifdef ALU_ISSUE_FORWARD_EN
    logic [REG_AW-1:0] in_rs1_i;
    logic [REG_AW-1:0] in_rs2_i;
`endif
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_src1_o;
    logic [DATA_W-1:0] out_src2_o;
    logic [3:0]        out_ctrl_o;
    logic [REG_AW-1:0] out_rd_o;
    logic              out_illegal_o;

    modport slave (
        input  in_valid_i, in_src1_i, in_src2_i, in_aluop_i, in_funct_i, in_rd_i,
`ifdef ALU_ISSUE_FORWARD_EN
        input  in_rs1_i, in_rs2_i,
`endif
        output in_ready_o,
        output out_valid_o, out_src1_o, out_src2_o, out_ctrl_o, out_rd_o, out_illegal_o,
        input  out_ready_i
    );

    modport master (
        output in_valid_i, in_src1_i, in_src2_i, in_aluop_i, in_funct_i, in_rd_i,
`ifdef ALU_ISSUE_FORWARD_EN
        output in_rs1_i, in_rs2_i,
`endif
        input  in_ready_o,
        input  out_valid_o, out_src1_o, out_src2_o, out_ctrl_o, out_rd_o, out_illegal_o,
        output out_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_dec
// Purpose  : Combinational ALUOp/funct -> 4-bit ALU control decoder.
//            Undecodable combinations yield ALU_BAD with illegal=1.
// Ports    : aluop   in  2  ALUOp from main control
//            funct   in  6  instruction funct field
//            ctrl    out 4  ALU control code
//            illegal out 1  combination not decodable
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output alu_ctrl_e  ctrl,
    output logic       illegal
);
    always_comb begin
        ctrl    = ALU_BAD;
        illegal = 1'b1;
        case (aluop)
            ALUOP_ADD: begin ctrl = ALU_ADD; illegal = 1'b0; end
            ALUOP_SUB: begin ctrl = ALU_SUB; illegal = 1'b0; end
            ALUOP_RTYPE: begin
                illegal = 1'b0;
                case (funct)
                    FUNCT_ADD: ctrl = ALU_ADD;
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_SLT: ctrl = ALU_SLT;
                    default: begin ctrl = ALU_BAD; illegal = 1'b1; end
                endcase
            end
            default: begin ctrl = ALU_BAD; illegal = 1'b1; end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Issue stage in front of the ALU. Decodes ALUOp/funct at capture
//            and holds up to two operations (main + skid) so in_ready_o is a
//            pure function of registered occupancy.
// Ports    : clk_i    in  clock, rising edge
//            rst_n_i  in  asynchronous active-low reset
//            flush_i  in  drop all buffered and incoming operations
//            bus      slave modport of alu_issue_stage_if (in_*/out_*)
//            wb_*     writeback bypass (ALU_ISSUE_FORWARD_EN only)
// Macros   : ALU_ISSUE_FORWARD_EN - enables writeback forwarding into
//            buffered operands via in_rs1_i/in_rs2_i and wb_* ports.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ISSUE_DATA_W,   // must equal ISSUE_DATA_W
    parameter int REG_AW = ISSUE_REG_AW    // must equal ISSUE_REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
`ifdef ALU_ISSUE_FORWARD_EN
    input  logic              wb_valid_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
`endif
    alu_issue_stage_if.slave  bus
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_out_valid;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_retire;
    issue_entry_t      r_main;
    issue_entry_t      r_skid;
    issue_entry_t      w_new_raw;
    issue_entry_t      w_new;
    issue_entry_t      w_main_fwd;
    issue_entry_t      w_skid_fwd;
    alu_ctrl_e         w_dec_ctrl;
    logic              w_dec_illegal;
    logic [DATA_W-1:0] w_in_src1;
    logic [DATA_W-1:0] w_in_src2;
    logic [REG_AW-1:0] w_in_rd;

    assign w_in_src1 = bus.in_src1_i;
    assign w_in_src2 = bus.in_src2_i;
    assign w_in_rd   = bus.in_rd_i;

    alu_ctrl_dec u_dec (
        .aluop   (bus.in_aluop_i),
        .funct   (bus.in_funct_i),
        .ctrl    (w_dec_ctrl),
        .illegal (w_dec_illegal)
    );

    always_comb begin
        w_new_raw         = '0;
        w_new_raw.src1    = w_in_src1;
        w_new_raw.src2    = w_in_src2;
        w_new_raw.ctrl    = w_dec_ctrl;
        w_new_raw.rd      = w_in_rd;
        w_new_raw.illegal = w_dec_illegal;
`ifdef ALU_ISSUE_FORWARD_EN
        w_new_raw.rs1     = bus.in_rs1_i;
        w_new_raw.rs2     = bus.in_rs2_i;
`endif
    end

    // Writeback bypass: a matching non-zero source tag takes the value being
    // written back this cycle, so buffered operands never go stale.
    function automatic issue_entry_t fwd(input issue_entry_t e);
        issue_entry_t r;
        r = e;
`ifdef ALU_ISSUE_FORWARD_EN
        if (wb_valid_i && (wb_rd_i != '0)) begin
            if (e.rs1 == wb_rd_i) r.src1 = wb_data_i;
            if (e.rs2 == wb_rd_i) r.src2 = wb_data_i;
        end
`endif
        return r;
    endfunction

    assign w_new      = fwd(w_new_raw);
    assign w_main_fwd = fwd(r_main);
    assign w_skid_fwd = fwd(r_skid);

    assign w_accept = bus.in_valid_i & w_in_ready;
    assign w_retire = w_out_valid & bus.out_ready_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_EMPTY;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_accept && !w_retire)      w_state_nxt = S_TWO;
                    else if (!w_accept && w_retire) w_state_nxt = S_EMPTY;
                end
                S_TWO:   if (w_retire) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Output logic: occupancy alone drives both handshake outputs
    always_comb begin
        w_out_valid = (r_state == S_ONE) || (r_state == S_TWO);
        w_in_ready  = (r_state != S_TWO);
    end

    // Entry data. Loads are gated only by occupancy; during a flush a load
    // may land in an entry that becomes invalid, which is harmless.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            r_main <= w_main_fwd;
            r_skid <= w_skid_fwd;
            case (r_state)
                S_EMPTY: if (w_accept) r_main <= w_new;
                S_ONE: begin
                    if (w_accept && w_retire) r_main <= w_new;
                    else if (w_accept)        r_skid <= w_new;
                end
                S_TWO:   if (w_retire) r_main <= w_skid_fwd;
                default: ;
            endcase
        end
    end

    assign bus.in_ready_o    = w_in_ready;
    assign bus.out_valid_o   = w_out_valid;
    assign bus.out_src1_o    = r_main.src1;
    assign bus.out_src2_o    = r_main.src2;
    assign bus.out_ctrl_o    = r_main.ctrl;
    assign bus.out_rd_o      = r_main.rd;
    assign bus.out_illegal_o = r_main.illegal;
endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Scoreboard bench for alu_issue_stage. Stimulus pushes the
//            hand-computed expected result when an op is accepted; a monitor
//            pops and compares every retired op.
// Macros   : ALU_ISSUE_FORWARD_EN - also exercises writeback forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
`ifdef ALU_ISSUE_FORWARD_EN
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd    = '0;
    logic [31:0] wb_data  = '0;
`endif

    always #5 clk = ~clk;

    alu_issue_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    alu_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
`ifdef ALU_ISSUE_FORWARD_EN
        .wb_valid_i (wb_valid),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
`endif
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rnd_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: the op is retired at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got src1=0x%0h ctrl=0x%0h required no output",
                         bus.out_src1_o, bus.out_ctrl_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_src1",    bus.out_src1_o, e.src1);
                chk("out_src2",    bus.out_src2_o, e.src2);
                chk("out_ctrl",    32'(bus.out_ctrl_o), 32'(e.ctrl));
                chk("out_rd",      32'(bus.out_rd_o), 32'(e.rd));
                chk("out_illegal", 32'(bus.out_illegal_o), 32'(e.ill));
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
    task automatic send(input logic [31:0] s1, input logic [31:0] s2,
                        input logic [1:0] op, input logic [5:0] fn, input logic [4:0] rd,
                        input logic [3:0] ectrl, input logic eill, input logic [31:0] es1);
        int k;
        bus.in_valid_i = 1'b1;
        bus.in_src1_i  = s1;
        bus.in_src2_i  = s2;
        bus.in_aluop_i = op;
        bus.in_funct_i = fn;
        bus.in_rd_i    = rd;
        k = 0;
        while (bus.in_ready_o !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (bus.in_ready_o !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=%b required 1", bus.in_ready_o);
            bus.in_valid_i = 1'b0;
            return;
        end
        sb.push_back('{es1, s2, ectrl, rd, eill});
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Decode table used only for the random stream.
    function automatic logic [4:0] model(input logic [1:0] op, input logic [5:0] fn);
        case (op)
            2'b00: return 5'b0_0010;
            2'b01: return 5'b0_0110;
            2'b10: case (fn)
                6'b100000: return 5'b0_0010;
                6'b100010: return 5'b0_0110;
                6'b100100: return 5'b0_0000;
                6'b100101: return 5'b0_0001;
                6'b101010: return 5'b0_0111;
                default:   return 5'b1_1111;
            endcase
            default: return 5'b1_1111;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] fn_tab [0:6];
        fn_tab[0] = 6'b100000; fn_tab[1] = 6'b100010; fn_tab[2] = 6'b100100;
        fn_tab[3] = 6'b100101; fn_tab[4] = 6'b101010; fn_tab[5] = 6'b000000;
        fn_tab[6] = 6'b111111;
        bus.in_valid_i  = 1'b0;
        bus.in_src1_i   = '0;
        bus.in_src2_i   = '0;
        bus.in_aluop_i  = '0;
        bus.in_funct_i  = '0;
        bus.in_rd_i     = '0;
        bus.out_ready_i = 1'b1;
`ifdef ALU_ISSUE_FORWARD_EN
        bus.in_rs1_i    = '0;
        bus.in_rs2_i    = '0;
`endif
        // Reset state
        cyc(3);
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready_o), 32'd1);
        chk("rst_src1",      bus.out_src1_o, 32'd0);
        chk("rst_src2",      bus.out_src2_o, 32'd0);
        chk("rst_ctrl",      32'(bus.out_ctrl_o), 32'd0);
        chk("rst_rd",        32'(bus.out_rd_o), 32'd0);
        chk("rst_illegal",   32'(bus.out_illegal_o), 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // R-type ADD, one-cycle latency
        send(32'd5, 32'd7, 2'b10, 6'b100000, 5'd3, 4'b0010, 1'b0, 32'd5);
        chk("latency_out_valid", 32'(bus.out_valid_o), 32'd1);
        cyc(2);

        // Fill both entries under backpressure, then drain in order
        bus.out_ready_i = 1'b0;
        send(32'd100, 32'd30, 2'b01, 6'b100100, 5'd7, 4'b0110, 1'b0, 32'd100);
        send(32'd9,   32'd12, 2'b10, 6'b101010, 5'd8, 4'b0111, 1'b0, 32'd9);
        chk("full_in_ready", 32'(bus.in_ready_o), 32'd0);
        cyc(1);
        chk("hold_src1", bus.out_src1_o, 32'd100);
        chk("hold_ctrl", 32'(bus.out_ctrl_o), 32'b0110);
        bus.out_ready_i = 1'b1;
        cyc(1);
        chk("drain_in_ready", 32'(bus.in_ready_o), 32'd1);
        cyc(1);
        chk("drain_out_valid", 32'(bus.out_valid_o), 32'd0);

        // Illegal combinations still flow through
        send(32'd1, 32'd2, 2'b10, 6'b000000, 5'd4, 4'b1111, 1'b1, 32'd1);
        send(32'd3, 32'd4, 2'b11, 6'b100000, 5'd5, 4'b1111, 1'b1, 32'd3);
        cyc(2);

        // Flush while full with an op offered
        bus.out_ready_i = 1'b0;
        send(32'd11, 32'd12, 2'b00, 6'b0, 5'd1, 4'b0010, 1'b0, 32'd11);
        send(32'd13, 32'd14, 2'b01, 6'b0, 5'd2, 4'b0110, 1'b0, 32'd13);
        bus.in_valid_i = 1'b1;
        bus.in_src1_i  = 32'h00C0_FFEE;
        bus.in_aluop_i = 2'b00;
        flush = 1'b1;
        sb.delete();
        cyc(1);
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("flush_in_ready",  32'(bus.in_ready_o), 32'd1);
        bus.out_ready_i = 1'b1;
        cyc(3);
        send(32'd21, 32'd22, 2'b10, 6'b100101, 5'd6, 4'b0001, 1'b0, 32'd21);
        cyc(2);

        // Reset in the middle of a full buffer
        bus.out_ready_i = 1'b0;
        send(32'd31, 32'd32, 2'b00, 6'b0, 5'd1, 4'b0010, 1'b0, 32'd31);
        send(32'd33, 32'd34, 2'b00, 6'b0, 5'd2, 4'b0010, 1'b0, 32'd33);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid_o), 32'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk("postrst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("postrst_in_ready",  32'(bus.in_ready_o), 32'd1);
        bus.out_ready_i = 1'b1;

        // 100 ops with random backpressure
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [1:0]  op;
                    logic [5:0]  fn;
                    logic [31:0] s2;
                    logic [4:0]  m;
                    op = 2'($urandom_range(0, 3));
                    fn = fn_tab[$urandom_range(0, 6)];
                    s2 = $urandom;
                    m  = model(op, fn);
                    send(32'(i + 1000), s2, op, fn, 5'(i), m[3:0], m[4], 32'(i + 1000));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    if (!rnd_done) bus.out_ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) cyc(1);
        chk("stream_drained", 32'(sb.size()), 32'd0);

`ifdef ALU_ISSUE_FORWARD_EN
        // Forward into a buffered op whose rs1 matches
        bus.out_ready_i = 1'b0;
        bus.in_rs1_i = 5'd4;
        send(32'd0, 32'd5, 2'b00, 6'b0, 5'd9, 4'b0010, 1'b0, 32'hDEAD_BEEF);
        bus.in_rs1_i = 5'd0;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'hDEAD_BEEF;
        cyc(1);
        wb_valid = 1'b0;
        chk("fwd_src1", bus.out_src1_o, 32'hDEAD_BEEF);
        bus.out_ready_i = 1'b1;
        cyc(2);
        // rs1 = 0 never forwards
        bus.out_ready_i = 1'b0;
        send(32'd0, 32'd5, 2'b00, 6'b0, 5'd9, 4'b0010, 1'b0, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
        cyc(1);
        wb_valid = 1'b0;
        chk("nofwd_src1", bus.out_src1_o, 32'd0);
        bus.out_ready_i = 1'b1;
        cyc(2);
`endif

        chk("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
